// File: rtl/aq_expand_pkg.sv
// aq_expand_pkg: shared constants, FSM encoding and pixel type for the
// nearest-neighbour upscaler.
package aq_expand_pkg;

  localparam int PIX_W  = 8;
  localparam int SIZE_W = 11;
  localparam int ACC_W  = 12;

  localparam logic [SIZE_W-1:0] SIZE_ZERO = {SIZE_W{1'b0}};
  localparam logic [SIZE_W-1:0] SIZE_ONE  = {{(SIZE_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } argb_t;

  // A frame cannot be upscaled when any size is zero or it would shrink.
  function automatic logic cfg_invalid(
    input logic [SIZE_W-1:0] org_x,
    input logic [SIZE_W-1:0] org_y,
    input logic [SIZE_W-1:0] cnv_x,
    input logic [SIZE_W-1:0] cnv_y
  );
    cfg_invalid = (org_x == SIZE_ZERO) | (org_y == SIZE_ZERO) |
                  (cnv_x == SIZE_ZERO) | (cnv_y == SIZE_ZERO) |
                  (cnv_x < org_x) | (cnv_y < org_y);
  endfunction

endpackage

// File: rtl/aq_expand_if.sv
// aq_expand_if: pixel-stream input, upscaled output and size configuration.
// master = pixel source / sink side, slave = the upscaler.
interface aq_expand_if #(
  parameter int PW = aq_expand_pkg::PIX_W
);
  import aq_expand_pkg::*;

  logic [SIZE_W-1:0] org_x;
  logic [SIZE_W-1:0] org_y;
  logic [SIZE_W-1:0] cnv_x;
  logic [SIZE_W-1:0] cnv_y;

  logic          din_we;
  logic          din_ready;
  logic          din_start_x;
  logic          din_start_y;
  logic [PW-1:0] din_a;
  logic [PW-1:0] din_r;
  logic [PW-1:0] din_g;
  logic [PW-1:0] din_b;

  logic          dout_oe;
  logic          dout_start_x;
  logic          dout_start_y;
  logic [PW-1:0] dout_a;
  logic [PW-1:0] dout_r;
  logic [PW-1:0] dout_g;
  logic [PW-1:0] dout_b;

  logic          cfg_err;

  modport master (
    output org_x, org_y, cnv_x, cnv_y,
    output din_we, din_start_x, din_start_y, din_a, din_r, din_g, din_b,
    input  din_ready,
    input  dout_oe, dout_start_x, dout_start_y, dout_a, dout_r, dout_g, dout_b,
    input  cfg_err
  );

  modport slave (
    input  org_x, org_y, cnv_x, cnv_y,
    input  din_we, din_start_x, din_start_y, din_a, din_r, din_g, din_b,
    output din_ready,
    output dout_oe, dout_start_x, dout_start_y, dout_a, dout_r, dout_g, dout_b,
    output cfg_err
  );

endinterface

// File: rtl/aq_expand_lbuf.sv
// aq_expand_lbuf: one-line buffer, simple dual-port RAM with a registered
// read port. Contents are never reset so it maps onto block RAM.
module aq_expand_lbuf #(
  parameter int AW = 11,
  parameter int DW = 4 * aq_expand_pkg::PIX_W
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_r
);
  import aq_expand_pkg::*;

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Write port: store one source pixel.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: one-cycle synchronous read.
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/aq_expand.sv
// aq_expand: nearest-neighbour upscaler. Buffers one source line, then
// replays it as many output rows as the vertical DDA asks for, stalling the
// source with din_ready while replaying.
module aq_expand #(
  parameter int LBUF_AW = 11,
  parameter int PIX_W   = aq_expand_pkg::PIX_W
) (
  input logic        CLK,
  input logic        RST_N,
  aq_expand_if.slave bus
);
  import aq_expand_pkg::*;

  localparam int DW = 4 * PIX_W;

  state_e            state_r;
  logic              din_ready_r;
  logic              cfg_err_r;
  logic              first_row_r;
  logic [SIZE_W-1:0] org_x_r, org_y_r, cnv_x_r, cnv_y_r;
  logic [SIZE_W-1:0] wx_r, sx_r, col_r, ys_r;
  logic [ACC_W-1:0]  acc_x_r, acc_y_r;

  logic              accept_s, frame_start_s, cfg_bad_s, wr_en_s;
  logic [SIZE_W-1:0] wr_col_s, wx_inc_s, ys_inc_s;
  logic              emit_s, row_end_s;
  logic [ACC_W-1:0]  acc_x_sum_s, acc_y_sum_s;
  logic [DW-1:0]     wr_data_s, rd_data_s;
  logic [LBUF_AW-1:0] wr_addr_s, rd_addr_s;

  logic              rd_vld_r, rd_sx_r, rd_sy_r;
  logic              dout_oe_r, dout_sx_r, dout_sy_r;
  logic [DW-1:0]     dout_pix_r;

  // Input handshake decode and line-buffer write column selection.
  always_comb begin
    accept_s      = bus.din_we & din_ready_r;
    frame_start_s = accept_s & bus.din_start_x & bus.din_start_y;
    cfg_bad_s     = cfg_invalid(bus.org_x, bus.org_y, bus.cnv_x, bus.cnv_y);
    wr_data_s     = {bus.din_a, bus.din_r, bus.din_g, bus.din_b};
    if (frame_start_s) begin
      wr_en_s  = ~cfg_bad_s;
      wr_col_s = SIZE_ZERO;
    end else if ((state_r == ST_FILL) && accept_s) begin
      wr_en_s  = 1'b1;
      wr_col_s = bus.din_start_x ? SIZE_ZERO : wx_r;
    end else begin
      wr_en_s  = 1'b0;
      wr_col_s = wx_r;
    end
    wx_inc_s = wr_col_s + SIZE_ONE;
  end

  // Horizontal / vertical DDA arithmetic for the row being emitted.
  always_comb begin
    emit_s      = (state_r == ST_EMIT);
    row_end_s   = (col_r == (cnv_x_r - SIZE_ONE));
    acc_x_sum_s = acc_x_r + {1'b0, org_x_r};
    acc_y_sum_s = acc_y_r + {1'b0, org_y_r};
    ys_inc_s    = ys_r + SIZE_ONE;
  end

  assign wr_addr_s = LBUF_AW'(wr_col_s);
  assign rd_addr_s = LBUF_AW'(sx_r);

  aq_expand_lbuf #(
    .AW (LBUF_AW),
    .DW (DW)
  ) u_lbuf (
    .CLK       (CLK),
    .wr_en     (wr_en_s),
    .wr_addr   (wr_addr_s),
    .wr_data   (wr_data_s),
    .rd_en     (emit_s),
    .rd_addr   (rd_addr_s),
    .rd_data_r (rd_data_s)
  );

  // Control FSM: frame sync, line fill, row replay with X/Y DDA, error drop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      din_ready_r <= 1'b0;
      cfg_err_r   <= 1'b0;
      first_row_r <= 1'b0;
      org_x_r     <= SIZE_ZERO;
      org_y_r     <= SIZE_ZERO;
      cnv_x_r     <= SIZE_ZERO;
      cnv_y_r     <= SIZE_ZERO;
      wx_r        <= SIZE_ZERO;
      sx_r        <= SIZE_ZERO;
      col_r       <= SIZE_ZERO;
      ys_r        <= SIZE_ZERO;
      acc_x_r     <= ACC_ZERO;
      acc_y_r     <= ACC_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_FILL, ST_DROP: begin
          if (frame_start_s) begin
            org_x_r     <= bus.org_x;
            org_y_r     <= bus.org_y;
            cnv_x_r     <= bus.cnv_x;
            cnv_y_r     <= bus.cnv_y;
            ys_r        <= SIZE_ZERO;
            acc_y_r     <= ACC_ZERO;
            acc_x_r     <= ACC_ZERO;
            sx_r        <= SIZE_ZERO;
            col_r       <= SIZE_ZERO;
            first_row_r <= 1'b1;
            cfg_err_r   <= cfg_bad_s;
            if (cfg_bad_s) begin
              state_r     <= ST_DROP;
              din_ready_r <= 1'b1;
              wx_r        <= SIZE_ZERO;
            end else if (wx_inc_s == bus.org_x) begin
              state_r     <= ST_EMIT;
              din_ready_r <= 1'b0;
              wx_r        <= SIZE_ZERO;
            end else begin
              state_r     <= ST_FILL;
              din_ready_r <= 1'b1;
              wx_r        <= wx_inc_s;
            end
          end else if ((state_r == ST_FILL) && accept_s) begin
            if (wx_inc_s == org_x_r) begin
              state_r     <= ST_EMIT;
              din_ready_r <= 1'b0;
              wx_r        <= SIZE_ZERO;
              acc_x_r     <= ACC_ZERO;
              sx_r        <= SIZE_ZERO;
              col_r       <= SIZE_ZERO;
            end else begin
              din_ready_r <= 1'b1;
              wx_r        <= wx_inc_s;
            end
          end else begin
            din_ready_r <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (row_end_s) begin
            col_r       <= SIZE_ZERO;
            sx_r        <= SIZE_ZERO;
            acc_x_r     <= ACC_ZERO;
            first_row_r <= 1'b0;
            if (acc_y_sum_s < {1'b0, cnv_y_r}) begin
              // Same source line is needed again: replay back-to-back.
              acc_y_r     <= acc_y_sum_s;
              din_ready_r <= 1'b0;
            end else begin
              acc_y_r     <= acc_y_sum_s - {1'b0, cnv_y_r};
              ys_r        <= ys_inc_s;
              wx_r        <= SIZE_ZERO;
              din_ready_r <= 1'b1;
              if (ys_inc_s == org_y_r) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_FILL;
              end
            end
          end else begin
            col_r       <= col_r + SIZE_ONE;
            din_ready_r <= 1'b0;
            if (acc_x_sum_s >= {1'b0, cnv_x_r}) begin
              acc_x_r <= acc_x_sum_s - {1'b0, cnv_x_r};
              sx_r    <= sx_r + SIZE_ONE;
            end else begin
              acc_x_r <= acc_x_sum_s;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          din_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Output pipeline: flags follow the RAM read, then register onto dout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_vld_r   <= 1'b0;
      rd_sx_r    <= 1'b0;
      rd_sy_r    <= 1'b0;
      dout_oe_r  <= 1'b0;
      dout_sx_r  <= 1'b0;
      dout_sy_r  <= 1'b0;
      dout_pix_r <= {DW{1'b0}};
    end else begin
      rd_vld_r   <= emit_s;
      rd_sx_r    <= emit_s & (col_r == SIZE_ZERO);
      rd_sy_r    <= emit_s & first_row_r;
      dout_oe_r  <= rd_vld_r;
      dout_sx_r  <= rd_vld_r & rd_sx_r;
      dout_sy_r  <= rd_vld_r & rd_sy_r;
      dout_pix_r <= rd_vld_r ? rd_data_s : {DW{1'b0}};
    end
  end

  assign bus.din_ready    = din_ready_r;
  assign bus.cfg_err      = cfg_err_r;
  assign bus.dout_oe      = dout_oe_r;
  assign bus.dout_start_x = dout_sx_r;
  assign bus.dout_start_y = dout_sy_r;
  assign bus.dout_a       = dout_pix_r[4*PIX_W-1:3*PIX_W];
  assign bus.dout_r       = dout_pix_r[3*PIX_W-1:2*PIX_W];
  assign bus.dout_g       = dout_pix_r[2*PIX_W-1:PIX_W];
  assign bus.dout_b       = dout_pix_r[PIX_W-1:0];

endmodule
